// File: rtl/mem_icache_dm.sv
// Direct-mapped instruction cache: tag/valid lookup, single-line refill on miss,
// and a sequenced valid-bit flush that walks every index once.
module mem_icache_dm #(
  parameter int unsigned LOG2CACHELINESIZE = 7,
  parameter int unsigned LOG2CACHEDEPTH    = 6,
  parameter int unsigned TAGSIZE           = 32 - LOG2CACHEDEPTH - LOG2CACHELINESIZE + 3,
  parameter int unsigned CACHELINESIZE     = 2 ** LOG2CACHELINESIZE
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              bus_address,
  input  logic                     bus_en,
  output logic [31:0]              bus_readdata,
  output logic                     bus_wait,
  input  logic                     bus_flush,
  output logic                     flush_busy,
  output logic                     mem_req,
  output logic [31:0]              mem_reqaddr,
  input  logic                     mem_ack,
  input  logic [CACHELINESIZE-1:0] mem_filldata,
  output logic                     cache_hit,
  output logic                     cache_miss
);

  localparam int unsigned OFF_W = LOG2CACHELINESIZE - 3;
  localparam int unsigned IDX_W = LOG2CACHEDEPTH;
  localparam int unsigned DEPTH = 2 ** LOG2CACHEDEPTH;
  localparam int unsigned SEL_W = LOG2CACHELINESIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [31:0]              addr_q;
  logic [DEPTH-1:0]         valid_q;
  logic [IDX_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic                     pending_q, pending_d;

  logic [CACHELINESIZE-1:0] data_mem [DEPTH];
  logic [TAGSIZE-1:0]       tag_mem  [DEPTH];
  logic [CACHELINESIZE-1:0] data_rd;
  logic [TAGSIZE-1:0]       tag_rd;

  logic [TAGSIZE-1:0]       addr_tag;
  logic [IDX_W-1:0]         addr_idx;
  logic [IDX_W-1:0]         bus_idx;
  logic [OFF_W-1:0]         line_off;
  logic [SEL_W-1:0]         bit_off;
  logic                     hit;
  logic                     flush_req;

  logic                     addr_ld;
  logic                     rd_en;
  logic [IDX_W-1:0]         rd_idx;
  logic                     fill_we;
  logic                     flush_clr;

  assign addr_tag  = addr_q[31:32-TAGSIZE];
  assign addr_idx  = addr_q[IDX_W+OFF_W-1:OFF_W];
  assign bus_idx   = bus_address[IDX_W+OFF_W-1:OFF_W];
  assign line_off  = addr_q[OFF_W-1:0];
  // Bit offset of the selected 32-bit word inside the line.
  assign bit_off   = {line_off, 3'b000} & ~SEL_W'(31);
  assign hit       = valid_q[addr_idx] && (tag_rd == addr_tag);
  // A flush pulse in the same cycle counts as pending so an idle flush starts at once.
  assign flush_req = pending_q | bus_flush;

  assign mem_reqaddr = {addr_q[31:OFF_W], OFF_W'(0)};
  assign flush_busy  = pending_q | (state_q == S_FLUSH);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state, datapath controls and bus-facing outputs
  always_comb begin
    state_d      = state_q;
    addr_ld      = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = addr_idx;
    fill_we      = 1'b0;
    flush_clr    = 1'b0;
    flush_cnt_d  = flush_cnt_q;
    pending_d    = flush_req;
    mem_req      = 1'b0;
    cache_hit    = 1'b0;
    cache_miss   = 1'b0;
    bus_wait     = bus_en;
    bus_readdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_d     = S_FLUSH;
          pending_d   = 1'b0;
          flush_cnt_d = IDX_W'(0);
        end else if (bus_en) begin
          addr_ld = 1'b1;
          rd_en   = 1'b1;
          rd_idx  = bus_idx;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          bus_wait     = 1'b0;
          cache_hit    = 1'b1;
          bus_readdata = data_rd[bit_off +: 32];
          if (flush_req) begin
            state_d     = S_FLUSH;
            pending_d   = 1'b0;
            flush_cnt_d = IDX_W'(0);
          end else if (bus_en) begin
            addr_ld = 1'b1;
            rd_en   = 1'b1;
            rd_idx  = bus_idx;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cache_miss = 1'b1;
          state_d    = S_MISS;
        end
      end

      S_MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          fill_we = resetn;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        rd_en   = 1'b1;
        state_d = S_LOOKUP;
      end

      S_FLUSH: begin
        flush_clr = 1'b1;
        pending_d = 1'b0;
        if (bus_flush) begin
          flush_cnt_d = IDX_W'(0);
        end else begin
          flush_cnt_d = flush_cnt_q + IDX_W'(1);
          if (flush_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Registered address, valid vector, flush walker and pending flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q      <= 32'd0;
      valid_q     <= '0;
      flush_cnt_q <= IDX_W'(0);
      pending_q   <= 1'b0;
    end else begin
      if (addr_ld)   addr_q <= bus_address;
      if (fill_we)   valid_q[addr_idx] <= 1'b1;
      if (flush_clr) valid_q[flush_cnt_q] <= 1'b0;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
    end
  end

  // Tag and data RAMs with one-cycle synchronous read
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[addr_idx] <= mem_filldata;
      tag_mem[addr_idx]  <= addr_tag;
    end
    if (rd_en) begin
      data_rd <= data_mem[rd_idx];
      tag_rd  <= tag_mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_mem_icache_dm.sv
// Directed bench for mem_icache_dm: miss/refill timing, streaming hits,
// index conflicts, flush sequencing and reset during an outstanding fill.
module tb_mem_icache_dm;

  logic         clk;
  logic         resetn;
  logic [31:0]  bus_address;
  logic         bus_en;
  logic [31:0]  bus_readdata;
  logic         bus_wait;
  logic         bus_flush;
  logic         flush_busy;
  logic         mem_req;
  logic [31:0]  mem_reqaddr;
  logic         mem_ack;
  logic [127:0] mem_filldata;
  logic         cache_hit;
  logic         cache_miss;

  int total = 0;
  int bad   = 0;

  mem_icache_dm dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus_address  (bus_address),
    .bus_en       (bus_en),
    .bus_readdata (bus_readdata),
    .bus_wait     (bus_wait),
    .bus_flush    (bus_flush),
    .flush_busy   (flush_busy),
    .mem_req      (mem_req),
    .mem_reqaddr  (mem_reqaddr),
    .mem_ack      (mem_ack),
    .mem_filldata (mem_filldata),
    .cache_hit    (cache_hit),
    .cache_miss   (cache_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Generic fill pattern: word w of the line at base is {base[15:0], 0xC0D, w}
  function automatic logic [127:0] mk_line(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = {base[15:0], 12'hC0D, 4'(w)};
    return l;
  endfunction

  // Full miss sequence from S_IDLE: checks miss pulse, request, hold, refill, replay hit
  task automatic fetch_miss(input logic [31:0] a, input logic [127:0] line,
                            input int delay, input logic [31:0] exp_word, input string nm);
    bus_address = a;
    bus_en      = 1'b1;
    #1;
    chk({nm, "_idle_wait"}, 32'(bus_wait), 32'd1);
    step();
    chk({nm, "_miss"}, 32'(cache_miss), 32'd1);
    chk({nm, "_lookup_req"}, 32'(mem_req), 32'd0);
    step();
    chk({nm, "_req"}, 32'(mem_req), 32'd1);
    chk({nm, "_reqaddr"}, mem_reqaddr, a & 32'hFFFF_FFF0);
    for (int d = 1; d < delay; d++) begin
      step();
      chk({nm, "_req_hold"}, 32'(mem_req), 32'd1);
    end
    mem_ack      = 1'b1;
    mem_filldata = line;
    step();
    mem_ack = 1'b0;
    chk({nm, "_req_drop"}, 32'(mem_req), 32'd0);
    chk({nm, "_refill_wait"}, 32'(bus_wait), 32'd1);
    step();
    chk({nm, "_replay_hit"}, 32'(cache_hit), 32'd1);
    chk({nm, "_replay_wait"}, 32'(bus_wait), 32'd0);
    chk({nm, "_replay_data"}, bus_readdata, exp_word);
    bus_en = 1'b0;
    step();
  endtask

  // Single hit from S_IDLE
  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp_word, input string nm);
    bus_address = a;
    bus_en      = 1'b1;
    step();
    chk({nm, "_hit"}, 32'(cache_hit), 32'd1);
    chk({nm, "_wait"}, 32'(bus_wait), 32'd0);
    chk({nm, "_data"}, bus_readdata, exp_word);
    bus_en = 1'b0;
    step();
  endtask

  // Count cycles with flush_busy high, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (flush_busy && n < 200) begin
      if (n == 10) begin
        bus_en = 1'b1;
        #1;
        chk("flush_bus_wait", 32'(bus_wait), 32'd1);
        bus_en = 1'b0;
      end
      n++;
      step();
    end
  endtask

  logic [127:0] line_a;
  logic [31:0]  exp_words [4];
  int           n;

  initial begin
    line_a       = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    exp_words[0] = 32'h1111_1111;
    exp_words[1] = 32'h2222_2222;
    exp_words[2] = 32'h3333_3333;
    exp_words[3] = 32'h4444_4444;

    resetn       = 1'b0;
    bus_address  = 32'd0;
    bus_en       = 1'b0;
    bus_flush    = 1'b0;
    mem_ack      = 1'b0;
    mem_filldata = '0;
    step();
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_hit", 32'(cache_hit), 32'd0);
    chk("rst_miss", 32'(cache_miss), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    chk("rst_readdata", bus_readdata, 32'd0);
    chk("rst_wait_lo", 32'(bus_wait), 32'd0);
    bus_en = 1'b1;
    #1;
    chk("rst_wait_follows", 32'(bus_wait), 32'd1);
    bus_en = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // First miss with a five-cycle memory response
    fetch_miss(32'h0000_1004, line_a, 5, 32'h2222_2222, "t1");

    // Back-to-back hits across the whole line
    bus_address = 32'h0000_1000;
    bus_en      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b2b_hit", 32'(cache_hit), 32'd1);
      chk("b2b_data", bus_readdata, exp_words[i]);
      chk("b2b_noreq", 32'(mem_req), 32'd0);
      if (i < 3) bus_address = 32'h0000_1000 + 32'(4 * (i + 1));
      else       bus_en = 1'b0;
    end
    step();

    // Index conflict: 0x1800 evicts 0x1000
    fetch_hit(32'h0000_1000, 32'h1111_1111, "t3a");
    fetch_miss(32'h0000_1800, mk_line(32'h0000_1800), 2, 32'h1800_C0D0, "t3b");
    fetch_miss(32'h0000_1000, line_a, 1, 32'h1111_1111, "t3c");

    // Idle flush after three resident lines
    fetch_miss(32'h0000_1010, mk_line(32'h0000_1010), 1, 32'h1010_C0D0, "t4a");
    fetch_miss(32'h0000_1028, mk_line(32'h0000_1020), 3, 32'h1020_C0D2, "t4b");
    bus_flush = 1'b1;
    #1;
    chk("flush_pulse_busy", 32'(flush_busy), 32'd0);
    step();
    bus_flush = 1'b0;
    count_busy(n);
    chk("flush_len", 32'(n), 32'd64);
    fetch_miss(32'h0000_1000, line_a, 1, 32'h1111_1111, "t4c");
    fetch_miss(32'h0000_102C, mk_line(32'h0000_1020), 1, 32'h1020_C0D3, "t4d");

    // Flush requested while a fill is outstanding
    bus_address = 32'h0000_1030;
    bus_en      = 1'b1;
    step();
    chk("t5_miss", 32'(cache_miss), 32'd1);
    step();
    bus_flush = 1'b1;
    #1;
    chk("t5_req", 32'(mem_req), 32'd1);
    step();
    bus_flush = 1'b0;
    chk("t5_pending", 32'(flush_busy), 32'd1);
    chk("t5_req_held", 32'(mem_req), 32'd1);
    step();
    chk("t5_req_held2", 32'(mem_req), 32'd1);
    mem_ack      = 1'b1;
    mem_filldata = mk_line(32'h0000_1030);
    step();
    mem_ack = 1'b0;
    chk("t5_refill_busy", 32'(flush_busy), 32'd1);
    chk("t5_refill_wait", 32'(bus_wait), 32'd1);
    step();
    chk("t5_hit", 32'(cache_hit), 32'd1);
    chk("t5_data", bus_readdata, 32'h1030_C0D0);
    bus_en = 1'b0;
    step();
    chk("t5_flushing", 32'(flush_busy), 32'd1);
    count_busy(n);
    chk("t5_flush_len", 32'(n), 32'd64);
    fetch_miss(32'h0000_1030, mk_line(32'h0000_1030), 1, 32'h1030_C0D0, "t5b");

    // Reset while mem_req is high, then a late ack
    bus_address = 32'h0000_1040;
    bus_en      = 1'b1;
    step();
    step();
    chk("t6_req", 32'(mem_req), 32'd1);
    resetn = 1'b0;
    bus_en = 1'b0;
    step();
    resetn = 1'b1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_miss_lo", 32'(cache_miss), 32'd0);
    mem_ack      = 1'b1;
    mem_filldata = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    step();
    mem_ack = 1'b0;
    chk("t6_late_req", 32'(mem_req), 32'd0);
    chk("t6_late_hit", 32'(cache_hit), 32'd0);
    chk("t6_late_wait", 32'(bus_wait), 32'd0);
    fetch_miss(32'h0000_1044, mk_line(32'h0000_1040), 2, 32'h1040_C0D1, "t6b");

    // Spurious ack in idle must not touch the resident line
    mem_ack      = 1'b1;
    mem_filldata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    step();
    mem_ack = 1'b0;
    chk("t6_spur_req", 32'(mem_req), 32'd0);
    fetch_hit(32'h0000_1044, 32'h1040_C0D1, "t6c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
